vga_capture: RTL

Receive-side counterpart of the scroller's VGA generator. Samples the 8-bit TinyTapeout VGA pin bundle, recovers line and frame timing from hsync/vsync, and locks onto a 640x480, 800x525 negative-sync raster. Emits a qualified pixel stream with coordinates, plus lock and timing-error status. Used in the FPGA companion board and the self-checking bench.

---
 rtl/vga_rx_pkg.sv | 37 +++
 rtl/vga_pin_sampler.sv | 44 ++++
 rtl/vga_capture.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_rx_pkg.sv
// Shared constants and types for the VGA capture path: pin map, default
// raster timing and the lock state machine encoding.
package vga_rx_pkg;

   // Pin positions inside the 8-bit TinyTapeout VGA bundle
   localparam int HSYNC_BIT = 7;
   localparam int VSYNC_BIT = 3;
   localparam int R_HI_BIT  = 0;
   localparam int R_LO_BIT  = 4;
   localparam int G_HI_BIT  = 1;
   localparam int G_LO_BIT  = 5;
   localparam int B_HI_BIT  = 2;
   localparam int B_LO_BIT  = 6;

   // Sync pins idle high, colour pins idle low
   localparam logic [7:0] PIN_IDLE = 8'h88;

   // Default 640x480 raster, 800x525 totals, negative sync
   localparam int unsigned H_TOTAL_DEF  = 800;
   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_OFFSET_DEF = 51;
   localparam int unsigned V_TOTAL_DEF  = 525;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_OFFSET_DEF = 34;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      HLOCK    = 2'd1,
      LOCKED   = 2'd2
   } rx_state_e;

   // Gathers a 2-bit colour channel, MSB pin first
   function automatic logic [1:0] pin_pair(input logic [7:0] pins, input int hi, input int lo);
      return {pins[hi], pins[lo]};
   endfunction

endpackage

// File: rtl/vga_pin_sampler.sv
// Input stage: registers the VGA pins once (S1), keeps a delayed copy of the
// sync pins (S2) and flags rising sync edges between the two.
module vga_pin_sampler
   import vga_rx_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] vga_in,
   output logic [1:0] s1_r,
   output logic [1:0] s1_g,
   output logic [1:0] s1_b,
   output logic       hsync_rise,
   output logic       vsync_rise
);

   logic [7:0] s1_d;
   logic [7:0] s1_q;
   logic [1:0] s2_d;
   logic [1:0] s2_q;

   // Next values: S1 takes the pins, S2 takes the S1 sync bits {hsync, vsync}
   always_comb begin
      s1_d = vga_in;
      s2_d = {s1_q[HSYNC_BIT], s1_q[VSYNC_BIT]};
   end

   // Sampling registers; sync idles high so no false edge appears after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= PIN_IDLE;
         s2_q <= 2'b11;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign s1_r       = pin_pair(s1_q, R_HI_BIT, R_LO_BIT);
   assign s1_g       = pin_pair(s1_q, G_HI_BIT, G_LO_BIT);
   assign s1_b       = pin_pair(s1_q, B_HI_BIT, B_LO_BIT);
   assign hsync_rise = s1_q[HSYNC_BIT] & ~s2_q[1];
   assign vsync_rise = s1_q[VSYNC_BIT] & ~s2_q[0];

endmodule

// File: rtl/vga_capture.sv
// VGA receiver: recovers line/frame timing from the sync pins, locks onto the
// expected raster and emits a qualified pixel stream with coordinates.
module vga_capture
   import vga_rx_pkg::*;
#(
   parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_OFFSET = H_OFFSET_DEF,
   parameter int unsigned V_TOTAL  = V_TOTAL_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_OFFSET = V_OFFSET_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] vga_in,
   output logic       pix_valid,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic [1:0] pix_r,
   output logic [1:0] pix_g,
   output logic [1:0] pix_b,
   output logic       line_start,
   output logic       frame_start,
   output logic       locked,
   output logic       hlen_err,
   output logic       vlen_err
);

   localparam logic [10:0] H_PERIOD = 11'(H_TOTAL);
   localparam logic [10:0] H_FIRST  = 11'(H_OFFSET);
   localparam logic [10:0] H_LAST   = 11'(H_OFFSET + H_ACTIVE - 1);
   localparam logic [9:0]  V_PERIOD = 10'(V_TOTAL);
   localparam logic [9:0]  V_FIRST  = 10'(V_OFFSET);
   localparam logic [9:0]  V_LAST   = 10'(V_OFFSET + V_ACTIVE - 1);
   localparam logic [9:0]  CNT_MAX  = 10'h3FF;

   logic [1:0] s1_r, s1_g, s1_b;
   logic       hsync_rise, vsync_rise;

   vga_pin_sampler u_sampler (
      .clk        (clk),
      .rst_n      (rst_n),
      .vga_in     (vga_in),
      .s1_r       (s1_r),
      .s1_g       (s1_g),
      .s1_b       (s1_b),
      .hsync_rise (hsync_rise),
      .vsync_rise (vsync_rise)
   );

   logic [9:0]  hcnt_d, hcnt_q;
   logic [9:0]  vcnt_d, vcnt_q;
   logic        seen_h_d, seen_h_q;
   logic        seen_v_d, seen_v_q;
   logic [10:0] hpos;
   logic        h_err, h_good, v_err;

   rx_state_e   state_d, state_q;
   logic        good_d, good_q;

   logic        in_win, line_first;
   logic        pix_valid_d, pix_valid_q;
   logic [9:0]  pix_x_d, pix_x_q, pix_y_d, pix_y_q;
   logic [1:0]  pix_r_d, pix_r_q, pix_g_d, pix_g_q, pix_b_d, pix_b_q;
   logic        line_start_d, line_start_q, frame_start_d, frame_start_q;
   logic        locked_d, locked_q, hlen_err_d, hlen_err_q, vlen_err_d, vlen_err_q;

   // Line/frame counters and period checks; hpos is clocks since the last hsync rise
   always_comb begin
      hpos     = {1'b0, hcnt_q} + 11'd1;
      h_err    = hsync_rise && seen_h_q && (hpos != H_PERIOD);
      h_good   = hsync_rise && seen_h_q && (hpos == H_PERIOD);
      v_err    = vsync_rise && seen_v_q && (vcnt_q != V_PERIOD);
      seen_h_d = seen_h_q | hsync_rise;
      seen_v_d = seen_v_q | vsync_rise;
      hcnt_d   = hcnt_q;
      if (hsync_rise) begin
         hcnt_d = 10'd0;
      end else if (hcnt_q != CNT_MAX) begin
         hcnt_d = hcnt_q + 10'd1;
      end
      vcnt_d = vcnt_q;
      if (vsync_rise) begin
         vcnt_d = hsync_rise ? 10'd1 : 10'd0;
      end else if (hsync_rise && (vcnt_q != CNT_MAX)) begin
         vcnt_d = vcnt_q + 10'd1;
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q   <= 10'd0;
         vcnt_q   <= 10'd0;
         seen_h_q <= 1'b0;
         seen_v_q <= 1'b0;
      end else begin
         hcnt_q   <= hcnt_d;
         vcnt_q   <= vcnt_d;
         seen_h_q <= seen_h_d;
         seen_v_q <= seen_v_d;
      end
   end

   // Lock tracking: two good lines give HLOCK, then a vsync gives LOCKED; a bad line always drops it
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      if (h_err) begin
         state_d = UNLOCKED;
         good_d  = 1'b0;
      end else begin
         case (state_q)
            UNLOCKED: begin
               if (h_good) begin
                  good_d = 1'b1;
                  if (good_q) begin
                     state_d = HLOCK;
                  end
               end
            end
            HLOCK: begin
               if (vsync_rise) begin
                  state_d = LOCKED;
               end
            end
            LOCKED:  state_d = LOCKED;
            default: state_d = UNLOCKED;
         endcase
      end
   end

   // Lock state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= UNLOCKED;
         good_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
      end
   end

   // Pixel window, coordinate counters and status pulses, all from the S1 cycle
   always_comb begin
      in_win = (state_q == LOCKED) && !hsync_rise &&
               (hpos >= H_FIRST) && (hpos <= H_LAST) &&
               (vcnt_q >= V_FIRST) && (vcnt_q <= V_LAST);
      line_first    = in_win && (hpos == H_FIRST);
      pix_valid_d   = in_win;
      line_start_d  = line_first;
      frame_start_d = line_first && (vcnt_q == V_FIRST);
      pix_x_d       = pix_x_q;
      pix_y_d       = pix_y_q;
      pix_r_d       = pix_r_q;
      pix_g_d       = pix_g_q;
      pix_b_d       = pix_b_q;
      if (in_win) begin
         pix_x_d = line_first ? 10'd0 : pix_x_q + 10'd1;
         pix_r_d = s1_r;
         pix_g_d = s1_g;
         pix_b_d = s1_b;
      end
      if (line_first) begin
         pix_y_d = (vcnt_q == V_FIRST) ? 10'd0 : pix_y_q + 10'd1;
      end
      locked_d   = (state_d == LOCKED);
      hlen_err_d = h_err;
      vlen_err_d = v_err;
   end

   // Output register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_valid_q   <= 1'b0;
         pix_x_q       <= 10'd0;
         pix_y_q       <= 10'd0;
         pix_r_q       <= 2'd0;
         pix_g_q       <= 2'd0;
         pix_b_q       <= 2'd0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         locked_q      <= 1'b0;
         hlen_err_q    <= 1'b0;
         vlen_err_q    <= 1'b0;
      end else begin
         pix_valid_q   <= pix_valid_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_r_q       <= pix_r_d;
         pix_g_q       <= pix_g_d;
         pix_b_q       <= pix_b_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         locked_q      <= locked_d;
         hlen_err_q    <= hlen_err_d;
         vlen_err_q    <= vlen_err_d;
      end
   end

   assign pix_valid   = pix_valid_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_r       = pix_r_q;
   assign pix_g       = pix_g_q;
   assign pix_b       = pix_b_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign locked      = locked_q;
   assign hlen_err    = hlen_err_q;
   assign vlen_err    = vlen_err_q;

endmodule
